oled_delay_scheduler: RTL and testbench
=======================================

# oled_delay_scheduler

Shared millisecond-delay timer for the OLED subsystem. The OLED init and refresh sequencers each need wall-clock waits (power-up, reset pulse, charge-pump settle). Instead of each one carrying its own wide counter, they request delays from this block. It arbitrates between requesters round-robin, runs a 100 MHz-to-1 kHz prescaler plus a down-counter for the granted requester, and pulses a per-requester done when the wait expires.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1000, delay unit rate; DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2
- DELAY_W, 16, width of one delay request in ticks

- clk_100MHz  in  1  system clock
- reset  in  1  reset; asynchronous, active-high; clock clk_100MHz
- req  in  NUM_REQ  per-requester request level; held until done or abort
- delay_ms  in  NUM_REQ*DELAY_W  packed delay per requester, slice i = bits [i*DELAY_W +: DELAY_W]
- grant  out  NUM_REQ  one-hot; the requester currently owning the timer
- done  out  NUM_REQ  one-cycle pulse to the granted requester at expiry
- busy  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state IDLE, grant 0, done 0, busy 0, rr_ptr 0, prescaler 0, remaining 0.
- IDLE
  - If any req is high, pick the first requester at or after rr_ptr (wrapping mod NUM_REQ).
  - Latch its delay_ms slice into remaining, clear the prescaler, set grant one-hot.
  - Set rr_ptr = (winner+1) mod NUM_REQ. Go to RUN.
- RUN
  - Prescaler increments each cycle. At DIV-1 it wraps to 0 and remaining decrements.
  - When remaining == 0 (checked before the increment), go to DONE.
  - If req[granted] deasserts: abort. Go to IDLE, clear grant, no done.
- DONE
  - done[granted] = 1 for exactly this cycle. grant stays high.
  - Next cycle go to IDLE and clear grant.
- delay_ms is sampled only at grant. Later changes are ignored.
- A requester must drop req in the cycle after done, or it is re-arbitrated as a new request.
- Delay 0 is legal: RUN → DONE on the first RUN cycle.
- remaining never underflows: the decrement is gated by remaining != 0.
- Prescaler width is $clog2(DIV). remaining width is DELAY_W.
- Requests arriving during RUN/DONE wait. Arbitration happens only in IDLE.

## Timing
- Req sampled high in IDLE at edge 0:
  - grant and busy high after edge 1.
  - done high after edge D*DIV+2, for one cycle.
  - grant and busy low after edge D*DIV+3.
- Earliest next grant: edge D*DIV+4, because one IDLE cycle is needed for arbitration.
- Abort: grant and busy low one edge after the edge that samples req low.
- Reset mid-operation: all outputs return to reset values asynchronously. No done is emitted.
- Simultaneous requests: the winner is decided by rr_ptr only. Losers keep req high and are served in rotation.

## Configuration
- OLED_DELAY_FAST_SIM_EN
  - Defined: DIV is forced to 10 regardless of CLK_HZ/TICK_HZ, so simulation delays are short. Synthesis builds must not define it.
  - Undefined: DIV = CLK_HZ/TICK_HZ (100000 by default).

## Structure
- Package oled_timing_pkg holds:
  - CLK_HZ_DEFAULT and TICK_HZ_DEFAULT constants
  - the FAST_SIM_DIV = 10 constant
  - the state enum typedef {IDLE, RUN, DONE}
- One sub-module, oled_tick_prescaler: counter 0..DIV-1 with synchronous clear and enable, outputting a one-cycle tick. The scheduler instantiates it, clears it at grant, and enables it in RUN.

## Test plan
All tests use OLED_DELAY_FAST_SIM_EN (DIV=10) and NUM_REQ=2.
- req[0]=1, delay 3 at edge 0 → grant=01 at edge 1; done[0] pulse at edge 32 only; busy low at edge 33.
- req[0]=1, delay 0 → done[0] at edge 2; no prescaler tick observed.
- req=11 held continuously after reset, delays 1/2 → grants in order 0, 1, 0, 1; each done matches its delay; never two grant bits set.
- req[0] dropped at edge 15 with delay 5 while req[1] is pending → no done[0]; grant=00 at edge 16; grant=10 at edge 17.
- reset pulsed at edge 20 of a delay-5 run → grant/done/busy 0 immediately; rr_ptr 0; next req[1] is granted normally.
- DELAY_W=4, delay 15 → done at edge 152; no wrap of remaining.

Source files
------------

// File: rtl/oled_timing_pkg.sv
// Shared timing constants and scheduler state type for the OLED delay timer.
// No logic lives here. Importing blocks take clock, tick and fast-sim divider defaults from it.
// It has no flow control of its own.
package oled_timing_pkg;

  localparam int CLK_HZ_DEFAULT  = 100_000_000;
  localparam int TICK_HZ_DEFAULT = 1000;
  localparam int FAST_SIM_DIV    = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/oled_tick_prescaler.sv
// Free-running 0..DIV-1 counter that emits a one-cycle tick on its last count.
// Latency: tick is combinational with the count at DIV-1, so it fires every DIV enabled cycles.
// Backpressure: none; enable pauses the count and clear zeroes it, with clear taking priority.
module oled_tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles and wrap at DIV-1; clear restarts the period at grant.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/oled_delay_scheduler.sv
// Shared millisecond delay timer: round-robin grant, prescaled down-count, one-cycle done per requester.
// Latency: grant one edge after req is sampled in IDLE, done D*DIV+1 edges after grant, then one IDLE cycle.
// Backpressure: requests wait while busy; dropping req of the granted requester aborts with no done.
// OLED_DELAY_FAST_SIM_EN forces the prescaler divider to FAST_SIM_DIV for short simulation delays.
module oled_delay_scheduler
  import oled_timing_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_DEFAULT,
  parameter int DELAY_W = 16
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DELAY_W-1:0]   delay_ms,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy
);

`ifdef OLED_DELAY_FAST_SIM_EN
  localparam int DIV = FAST_SIM_DIV;
`else
  localparam int DIV = CLK_HZ / TICK_HZ;
`endif

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t        state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_nxt;
  logic [PTR_W-1:0]    gnt_idx, idx_nxt;
  logic [DELAY_W-1:0]  remaining, rem_nxt;
  logic                presc_clear, presc_en, tick;
  logic                found;
  int                  win;

  oled_tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (presc_clear),
    .enable     (presc_en),
    .tick       (tick)
  );

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count down in RUN, pulse done for one cycle.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_nxt      = rr_ptr;
    idx_nxt     = gnt_idx;
    rem_nxt     = remaining;
    presc_clear = 1'b0;
    presc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = RUN;
          grant_nxt   = NUM_REQ'(1) << win;
          idx_nxt     = PTR_W'(win);
          rr_nxt      = (win == NUM_REQ - 1) ? '0 : PTR_W'(win + 1);
          rem_nxt     = delay_ms[win*DELAY_W +: DELAY_W];
          presc_clear = 1'b1;
        end
      end
      RUN: begin
        // An abort outranks expiry so a dropped request never sees done.
        if (!req[gnt_idx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (remaining == '0) begin
          state_nxt = DONE;
        end else begin
          presc_en = 1'b1;
          if (tick) rem_nxt = remaining - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      gnt_idx   <= idx_nxt;
      remaining <= rem_nxt;
    end
  end

  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_oled_delay_scheduler.sv
// Self-checking bench for oled_delay_scheduler with a divider of 10 (CLK_HZ/TICK_HZ = 10).
// Edge numbering: inputs are driven just after "edge 0", and outputs are sampled 1 ns after edge e.
// A second instance with DELAY_W=4 covers the full-range delay without wrap.
module tb_oled_delay_scheduler;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  req        = '0;
  logic [31:0] delay_ms   = '0;
  logic [1:0]  grant, done;
  logic        busy;
  logic [1:0]  req4       = '0;
  logic [7:0]  delay4     = '0;
  logic [1:0]  grant4, done4;
  logic        busy4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  oled_delay_scheduler #(
    .NUM_REQ(2), .CLK_HZ(10_000), .TICK_HZ(1000), .DELAY_W(16)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .req        (req),
    .delay_ms   (delay_ms),
    .grant      (grant),
    .done       (done),
    .busy       (busy)
  );

  oled_delay_scheduler #(
    .NUM_REQ(2), .CLK_HZ(10_000), .TICK_HZ(1000), .DELAY_W(4)
  ) dut4 (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .req        (req4),
    .delay_ms   (delay4),
    .grant      (grant4),
    .done       (done4),
    .busy       (busy4)
  );

  typedef struct {
    int         who;
    int         delay;
    int         done_edge;
    logic [1:0] exp_grant;
  } vec_t;

  typedef struct {
    int g;
    int d;
    int who;
  } seg_t;

  vec_t vecs[5];
  seg_t segs[4];

  task automatic check(input string name, input int edge_no,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Leaves the bench 1 ns after "edge 0" with both DUTs idle and all requests low.
  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    req4  = '0;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    tick_edge();
  endtask

  initial begin
    // Hand-computed single-request runs: done at D*10+2, grant from edge 1.
    vecs[0] = '{who: 0, delay: 3, done_edge: 32, exp_grant: 2'b01};
    vecs[1] = '{who: 0, delay: 0, done_edge: 2,  exp_grant: 2'b01};
    vecs[2] = '{who: 1, delay: 2, done_edge: 22, exp_grant: 2'b10};
    vecs[3] = '{who: 1, delay: 1, done_edge: 12, exp_grant: 2'b10};
    vecs[4] = '{who: 0, delay: 7, done_edge: 72, exp_grant: 2'b01};

    // Round-robin with req=11 held, delays 1 (req 0) and 2 (req 1).
    segs[0] = '{g: 1,  d: 1, who: 0};
    segs[1] = '{g: 14, d: 2, who: 1};
    segs[2] = '{g: 37, d: 1, who: 0};
    segs[3] = '{g: 50, d: 2, who: 1};

    // Reset state while reset is held.
    #1;
    check("reset_grant", 0, grant, 2'b00);
    check("reset_done",  0, done,  2'b00);
    check("reset_busy",  0, busy,  1'b0);
    check("reset_rrptr", 0, dut.rr_ptr, 0);
    check("reset_grant4", 0, grant4, 2'b00);

    // Table-driven single-request delays.
    apply_reset();
    for (int v = 0; v < 5; v++) begin
      logic tick_seen;
      tick_seen = 1'b0;
      delay_ms = '0;
      delay_ms[vecs[v].who*16 +: 16] = 16'(vecs[v].delay);
      req = 2'b00;
      req[vecs[v].who] = 1'b1;
      for (int e = 1; e <= vecs[v].done_edge + 1; e++) begin
        tick_edge();
        if (dut.u_presc.tick) tick_seen = 1'b1;
        check($sformatf("vec%0d_grant", v), e, grant,
              (e <= vecs[v].done_edge) ? vecs[v].exp_grant : 2'b00);
        check($sformatf("vec%0d_done", v), e, done,
              (e == vecs[v].done_edge) ? vecs[v].exp_grant : 2'b00);
        check($sformatf("vec%0d_busy", v), e, busy,
              (e <= vecs[v].done_edge) ? 1'b1 : 1'b0);
        // Changing delay after grant must not affect the running wait.
        if (e == 1) delay_ms = '1;
        if (e == vecs[v].done_edge) req = 2'b00;
      end
      if (vecs[v].delay == 0) check("delay0_no_tick", vecs[v].done_edge, tick_seen, 1'b0);
    end

    // Round-robin alternation with both requests held.
    apply_reset();
    delay_ms = {16'd2, 16'd1};
    req = 2'b11;
    for (int e = 1; e <= 72; e++) begin
      logic [1:0] eg, ed;
      logic       eb;
      eg = '0; ed = '0; eb = 1'b0;
      tick_edge();
      for (int s = 0; s < 4; s++) begin
        int last;
        last = segs[s].g + segs[s].d * 10 + 1;
        if (e >= segs[s].g && e <= last) begin
          eg = 2'b00;
          eg[segs[s].who] = 1'b1;
          eb = 1'b1;
          if (e == last) ed = eg;
        end
      end
      check("rr_grant", e, grant, eg);
      check("rr_done",  e, done,  ed);
      check("rr_busy",  e, busy,  eb);
      check("rr_onehot", e, ($countones(grant) <= 1), 1'b1);
      if (e == 71) req = 2'b00;
    end

    // Abort of requester 0 while requester 1 waits.
    apply_reset();
    delay_ms = {16'd3, 16'd5};
    req = 2'b11;
    for (int e = 1; e <= 49; e++) begin
      logic [1:0] eg;
      eg = (e <= 15) ? 2'b01 : (e == 16) ? 2'b00 : (e <= 48) ? 2'b10 : 2'b00;
      tick_edge();
      check("abort_grant", e, grant, eg);
      check("abort_done",  e, done, (e == 48) ? 2'b10 : 2'b00);
      check("abort_busy",  e, busy, (eg != 2'b00));
      if (e == 15) req = 2'b10;
      if (e == 48) req = 2'b00;
    end

    // Asynchronous reset in the middle of a delay-5 wait.
    apply_reset();
    delay_ms = {16'd2, 16'd5};
    req = 2'b01;
    repeat (20) tick_edge();
    check("midrun_grant_before", 20, grant, 2'b01);
    reset = 1'b1;
    #1;
    check("midrun_grant", 20, grant, 2'b00);
    check("midrun_done",  20, done,  2'b00);
    check("midrun_busy",  20, busy,  1'b0);
    check("midrun_rrptr", 20, dut.rr_ptr, 0);
    req = 2'b10;
    @(negedge clk_100MHz);
    reset = 1'b0;
    for (int e = 1; e <= 23; e++) begin
      tick_edge();
      check("post_reset_grant", e, grant, (e <= 22) ? 2'b10 : 2'b00);
      check("post_reset_done",  e, done,  (e == 22) ? 2'b10 : 2'b00);
      if (e == 22) req = 2'b00;
    end

    // Full-range 4-bit delay: 15 ticks, no wrap of remaining.
    apply_reset();
    delay4 = {4'd0, 4'd15};
    req4 = 2'b01;
    for (int e = 1; e <= 153; e++) begin
      tick_edge();
      check("w4_grant", e, grant4, (e <= 152) ? 2'b01 : 2'b00);
      check("w4_done",  e, done4,  (e == 152) ? 2'b01 : 2'b00);
      check("w4_busy",  e, busy4,  (e <= 152) ? 1'b1 : 1'b0);
      if (e == 152) req4 = 2'b00;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
